// File: rtl/fifo_param.sv
// Parametrised show-ahead synchronous FIFO with occupancy count and full/almost-full flags.
// Define FIFO_ERR_FLAG_EN to add sticky overflow/underflow outputs.
module fifo_param #(
  parameter int width        = 8,
  parameter int depth        = 16,
  parameter int afull_thresh = depth - 2
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         write_i,
  input  logic [width-1:0]             data_i,
  input  logic                         read_i,
  output logic [width-1:0]             data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic                         afull_o,
  output logic [$clog2(depth+1)-1:0]   count_o
`ifdef FIFO_ERR_FLAG_EN
  ,
  output logic                         ovf_o,
  output logic                         udf_o
`endif
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(depth - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(depth);
  localparam logic [CW-1:0] AFULL_C  = CW'(afull_thresh);

  logic [width-1:0] r_mem [depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_afull;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [CW-1:0]    w_count_nxt;

  // A full FIFO still takes a write when the head is popped in the same cycle.
  assign w_wr_acc = write_i & (~r_full | read_i);
  assign w_rd_acc = read_i & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Flags are registered from the next count so no input reaches an output combinationally.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == DEPTH_C);
      r_afull <= (w_count_nxt >= AFULL_C);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= data_i;
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign empty_o = r_empty;
  assign full_o  = r_full;
  assign afull_o = r_afull;
  assign count_o = r_count;

`ifdef FIFO_ERR_FLAG_EN
  logic r_ovf;
  logic r_udf;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (write_i & r_full & ~read_i) r_ovf <= 1'b1;
      if (read_i & r_empty)           r_udf <= 1'b1;
    end
  end

  assign ovf_o = r_ovf;
  assign udf_o = r_udf;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param: a depth-16 instance for fill/drain/overflow
// and a depth-5 instance for pointer wrap and asynchronous reset.
module tb_fifo_param;

  logic       clk;
  logic       rstn;

  logic       wr16, rd16;
  logic [7:0] din16, dout16;
  logic       empty16, full16, afull16;
  logic [4:0] cnt16;

  logic       wr5, rd5;
  logic [7:0] din5, dout5;
  logic       empty5, full5, afull5;
  logic [2:0] cnt5;

`ifdef FIFO_ERR_FLAG_EN
  logic ovf16, udf16, ovf5, udf5;
`endif

  int errors = 0;
  int checks = 0;

  fifo_param #(.width(8), .depth(16), .afull_thresh(14)) dut16 (
    .clk_i(clk), .rstn_i(rstn), .write_i(wr16), .data_i(din16), .read_i(rd16),
    .data_o(dout16), .empty_o(empty16), .full_o(full16), .afull_o(afull16),
    .count_o(cnt16)
`ifdef FIFO_ERR_FLAG_EN
    , .ovf_o(ovf16), .udf_o(udf16)
`endif
  );

  fifo_param #(.width(8), .depth(5), .afull_thresh(3)) dut5 (
    .clk_i(clk), .rstn_i(rstn), .write_i(wr5), .data_i(din5), .read_i(rd5),
    .data_o(dout5), .empty_o(empty5), .full_o(full5), .afull_o(afull5),
    .count_o(cnt5)
`ifdef FIFO_ERR_FLAG_EN
    , .ovf_o(ovf5), .udf_o(udf5)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    wr16 = 0; rd16 = 0; din16 = 0;
    wr5 = 0; rd5 = 0; din5 = 0;
    #70;
    rstn = 1'b1;
    #1;
    checks++; if (empty16 !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got=%b exp=1", empty16); end
    checks++; if (full16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got=%b exp=0", full16); end
    checks++; if (cnt16 !== 5'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", cnt16); end
    checks++; if (afull16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_afull got=%b exp=0", afull16); end
    checks++; if (empty5 !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty5 got=%b exp=1", empty5); end
`ifdef FIFO_ERR_FLAG_EN
    checks++; if (ovf16 !== 1'b0 || udf16 !== 1'b0) begin errors++; $display("[TB] FAIL reset_errflags got=%b%b exp=00", ovf16, udf16); end
`endif
  endtask

  task automatic fill16(input int base);
    for (int i = 1; i <= 16; i++) begin
      wr16 = 1'b1; rd16 = 1'b0; din16 = 8'(base + i - 1);
      step();
      checks++; if (cnt16 !== 5'(i)) begin errors++; $display("[TB] FAIL fill_count[%0d] got=%0d exp=%0d", i, cnt16, i); end
      checks++; if (afull16 !== (i >= 14)) begin errors++; $display("[TB] FAIL fill_afull[%0d] got=%b exp=%b", i, afull16, (i >= 14)); end
      checks++; if (full16 !== (i == 16)) begin errors++; $display("[TB] FAIL fill_full[%0d] got=%b exp=%b", i, full16, (i == 16)); end
      checks++; if (empty16 !== 1'b0) begin errors++; $display("[TB] FAIL fill_empty[%0d] got=%b exp=0", i, empty16); end
      checks++; if (dout16 !== 8'(base)) begin errors++; $display("[TB] FAIL fill_head[%0d] got=%0h exp=%0h", i, dout16, 8'(base)); end
    end
    wr16 = 1'b0;
  endtask

  task automatic test_fill();
    fill16(1);
  endtask

  task automatic test_overflow();
    wr16 = 1'b1; rd16 = 1'b0; din16 = 8'hAA;
    step();
    wr16 = 1'b0;
    checks++; if (cnt16 !== 5'd16) begin errors++; $display("[TB] FAIL ovf_count got=%0d exp=16", cnt16); end
    checks++; if (full16 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full got=%b exp=1", full16); end
    checks++; if (dout16 !== 8'd1) begin errors++; $display("[TB] FAIL ovf_head got=%0h exp=1", dout16); end
`ifdef FIFO_ERR_FLAG_EN
    checks++; if (ovf16 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got=%b exp=1", ovf16); end
    step();
    checks++; if (ovf16 !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky got=%b exp=1", ovf16); end
    checks++; if (udf16 !== 1'b0) begin errors++; $display("[TB] FAIL ovf_udf_clear got=%b exp=0", udf16); end
`endif
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 17; i++) begin
      rd16 = 1'b1; wr16 = 1'b0;
      if (i <= 16) begin
        checks++; if (dout16 !== 8'(i)) begin errors++; $display("[TB] FAIL drain_data[%0d] got=%0h exp=%0h", i, dout16, 8'(i)); end
      end
      step();
      checks++; if (cnt16 !== 5'((i <= 16) ? 16 - i : 0)) begin errors++; $display("[TB] FAIL drain_count[%0d] got=%0d exp=%0d", i, cnt16, (i <= 16) ? 16 - i : 0); end
      checks++; if (empty16 !== (i >= 16)) begin errors++; $display("[TB] FAIL drain_empty[%0d] got=%b exp=%b", i, empty16, (i >= 16)); end
    end
    rd16 = 1'b0;
    checks++; if (full16 !== 1'b0) begin errors++; $display("[TB] FAIL drain_full got=%b exp=0", full16); end
`ifdef FIFO_ERR_FLAG_EN
    checks++; if (udf16 !== 1'b1) begin errors++; $display("[TB] FAIL udf_flag got=%b exp=1", udf16); end
`endif
  endtask

  task automatic test_simul_full();
    fill16(1);
    wr16 = 1'b1; rd16 = 1'b1; din16 = 8'h55;
    step();
    wr16 = 1'b0; rd16 = 1'b0;
    checks++; if (cnt16 !== 5'd16) begin errors++; $display("[TB] FAIL simfull_count got=%0d exp=16", cnt16); end
    checks++; if (full16 !== 1'b1) begin errors++; $display("[TB] FAIL simfull_full got=%b exp=1", full16); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i < 15) ? 8'(i + 2) : 8'h55;
      rd16 = 1'b1;
      checks++; if (dout16 !== exp) begin errors++; $display("[TB] FAIL simfull_order[%0d] got=%0h exp=%0h", i, dout16, exp); end
      step();
    end
    rd16 = 1'b0;
    checks++; if (empty16 !== 1'b1) begin errors++; $display("[TB] FAIL simfull_empty got=%b exp=1", empty16); end
  endtask

  task automatic test_simul_empty();
    wr16 = 1'b1; rd16 = 1'b1; din16 = 8'h33;
    step();
    wr16 = 1'b0; rd16 = 1'b0;
    checks++; if (cnt16 !== 5'd1) begin errors++; $display("[TB] FAIL simempty_count got=%0d exp=1", cnt16); end
    checks++; if (empty16 !== 1'b0) begin errors++; $display("[TB] FAIL simempty_empty got=%b exp=0", empty16); end
    checks++; if (dout16 !== 8'h33) begin errors++; $display("[TB] FAIL simempty_data got=%0h exp=33", dout16); end
    rd16 = 1'b1;
    step();
    rd16 = 1'b0;
    checks++; if (cnt16 !== 5'd0) begin errors++; $display("[TB] FAIL simempty_pop got=%0d exp=0", cnt16); end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int got  = 0;
    for (int cyc = 0; cyc < 100 && got < 20; cyc++) begin
      wr5  = (sent < 20);
      din5 = 8'(sent);
      rd5  = ~empty5;
      if (rd5) begin
        checks++; if (dout5 !== 8'(got)) begin errors++; $display("[TB] FAIL wrap_order[%0d] got=%0d exp=%0d", got, dout5, got); end
        got++;
      end
      step();
      if (wr5) sent++;
    end
    wr5 = 1'b0; rd5 = 1'b0;
    checks++; if (got != 20) begin errors++; $display("[TB] FAIL wrap_timeout received=%0d exp=20", got); end
    checks++; if (cnt5 !== 3'd0) begin errors++; $display("[TB] FAIL wrap_final_count got=%0d exp=0", cnt5); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      wr5 = 1'b1; din5 = 8'(8'hA0 + k);
      step();
    end
    wr5 = 1'b0;
    checks++; if (cnt5 !== 3'd3) begin errors++; $display("[TB] FAIL hold_count got=%0d exp=3", cnt5); end
    checks++; if (dout5 !== 8'hA0) begin errors++; $display("[TB] FAIL hold_head got=%0h exp=a0", dout5); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (empty5 !== 1'b1) begin errors++; $display("[TB] FAIL areset_empty got=%b exp=1", empty5); end
    checks++; if (cnt5 !== 3'd0) begin errors++; $display("[TB] FAIL areset_count got=%0d exp=0", cnt5); end
    checks++; if (afull5 !== 1'b0) begin errors++; $display("[TB] FAIL areset_afull got=%b exp=0", afull5); end
`ifdef FIFO_ERR_FLAG_EN
    checks++; if (ovf16 !== 1'b0 || udf16 !== 1'b0) begin errors++; $display("[TB] FAIL areset_errflags got=%b%b exp=00", ovf16, udf16); end
`endif
    #20;
    rstn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_simul_full();
    test_simul_empty();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
